uart_rx_frame: RTL and testbench

//  UART receiver, the receive counterpart of the existing 11-bit transmit path.

---
 rtl/uart_rx_frame.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// ============================================================================
// Module   : uart_rx_frame
// Brief    : 16x-oversampled UART receiver, 8 data bits LSB first + parity + stop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_frame #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int                 c_DIV      = CLK_FREQ / (BAUD * 16);
    localparam int                 c_DIV_W    = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIV - 1);
    localparam logic               c_ODD      = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic               r_sync1;
    logic               r_rx_s;
    logic               r_rx_prev;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic [3:0]         r_sub_cnt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shreg;
    logic               r_par_bit;

    logic w_fall;
    logic w_tick;
    logic w_mid_start;
    logic w_bit_end;

    assign w_fall      = r_rx_prev & ~r_rx_s;
    assign w_tick      = (r_div_cnt == c_DIV_LAST);
    assign w_mid_start = w_tick && (r_sub_cnt == 4'd7);
    assign w_bit_end   = w_tick && (r_sub_cnt == 4'd15);
    assign busy        = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
        end
    end

    // Divider restarts on the start edge so ticks line up with the bit phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if ((r_state == S_IDLE && w_fall) || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + c_DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fall) w_state_next = S_START;
            end
            S_START: begin
                if (w_mid_start) w_state_next = r_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_bit_end && r_bit_cnt == 3'd7) w_state_next = S_PARITY;
            end
            S_PARITY: begin
                if (w_bit_end) w_state_next = S_STOP;
            end
            S_STOP: begin
                if (w_bit_end) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sub_cnt  <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_shreg    <= 8'h00;
            r_par_bit  <= 1'b0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_sub_cnt <= 4'd0;
                        r_bit_cnt <= 3'd0;
                    end
                end
                S_START: begin
                    if (w_mid_start) begin
                        r_sub_cnt <= 4'd0;
                    end else if (w_tick) begin
                        r_sub_cnt <= r_sub_cnt + 4'd1;
                    end
                end
                S_DATA: begin
                    if (w_tick) r_sub_cnt <= r_sub_cnt + 4'd1;
                    if (w_bit_end) begin
                        r_shreg <= {r_rx_s, r_shreg[7:1]};
                        if (r_bit_cnt != 3'd7) r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end
                S_PARITY: begin
                    if (w_tick) r_sub_cnt <= r_sub_cnt + 4'd1;
                    if (w_bit_end) r_par_bit <= r_rx_s;
                end
                S_STOP: begin
                    if (w_tick) r_sub_cnt <= r_sub_cnt + 4'd1;
                    // Results become visible the clock after the stop-bit sample.
                    if (w_bit_end) begin
                        data_out   <= r_shreg;
                        parity_err <= ((^r_shreg) ^ r_par_bit) != c_ODD;
                        frame_err  <= ~r_rx_s;
                        data_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
// ============================================================================
// Module   : tb_uart_rx_frame
// Brief    : Scoreboard bench for uart_rx_frame at 16 clk/bit, even parity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    int   valid_cyc[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    uart_rx_frame #(
        .CLK_FREQ  (1_600_000),
        .BAUD      (100_000),
        .PARITY_ODD(0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_out  (data_out),
        .data_valid(data_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every data_valid pulse pops one expected frame.
    always @(negedge clk) begin
        if (data_valid) begin
            exp_t e;
            valid_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: actual=data_valid 1 with data_out %0h required=no pulse", data_out);
            end else begin
                e = exp_q.pop_front();
                check("data_out", {24'd0, data_out}, {24'd0, e.d});
                check("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
                check("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
                check("busy_at_valid", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        rx = 1'b0;
        wait_clks(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(16);
        end
        rx = par;
        wait_clks(16);
        rx = stop;
        wait_clks(16);
    endtask

    initial begin
        int nv;
        int nb;

        rst = 1'b1;
        rx  = 1'b1;
        wait_clks(5);
        check("rst_data_out", {24'd0, data_out}, 32'h00);
        check("rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("rst_parity_err", {31'd0, parity_err}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        wait_clks(10);

        // 1: clean frame
        expect_frame(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_clks(4);
        check("t1_drained", exp_q.size(), 32'd0);

        // 2: wrong parity (0x01 has odd weight, even parity needs 1)
        expect_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h01, 1'b0, 1'b1);
        wait_clks(4);
        check("t2_drained", exp_q.size(), 32'd0);

        // 3: stop bit low, then line held low
        expect_frame(8'h5A, 1'b0, 1'b1);
        send_frame(8'h5A, 1'b0, 1'b0);
        wait_clks(40);
        check("t3_valid_count", valid_cyc.size(), 32'd3);
        rx = 1'b1;
        wait_clks(20);
        check("t3_no_extra_valid", valid_cyc.size(), 32'd3);

        // 4: 4-clock glitch is a false start
        nv = valid_cyc.size();
        nb = 0;
        rx = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) rx = 1'b1;
            if (busy) nb++;
        end
        check("t4_busy_clks", nb, 32'd8);
        check("t4_no_valid", valid_cyc.size(), nv);
        check("t4_data_hold", {24'd0, data_out}, 32'h5A);
        check("t4_frame_err_hold", {31'd0, frame_err}, 32'd1);
        check("t4_busy_idle", {31'd0, busy}, 32'd0);

        // 5: reset during data bits of 0xFF
        nv = valid_cyc.size();
        rx = 1'b0;
        wait_clks(16);
        rx = 1'b1;
        wait_clks(48);
        check("t5_busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        wait_clks(1);
        check("t5_rst_data_out", {24'd0, data_out}, 32'h00);
        check("t5_rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("t5_rst_parity_err", {31'd0, parity_err}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        wait_clks(3);
        rst = 1'b0;
        wait_clks(200);
        check("t5_no_valid", valid_cyc.size(), nv);
        check("t5_busy_idle", {31'd0, busy}, 32'd0);
        expect_frame(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1);
        wait_clks(4);
        check("t5_drained", exp_q.size(), 32'd0);

        // 6: back-to-back frames, no idle gap
        nv = valid_cyc.size();
        expect_frame(8'h00, 1'b0, 1'b0);
        expect_frame(8'hFF, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        wait_clks(20);
        check("t6_valid_count", valid_cyc.size(), nv + 2);
        if (valid_cyc.size() >= 2)
            check("t6_spacing", valid_cyc[$] - valid_cyc[$-1], 32'd176);

        check("final_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
